// File: rtl/control_fsm.sv
// CR16 multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/LOAD_WB, owns PC/IR/PSR,
// and drives every datapath and memory control input combinationally from state and IR.
module control_fsm #(
  parameter logic [15:0] PC_RESET_VALUE = 16'h0000
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic [15:0] I_MEM_DATA,
  input  logic [15:0] I_A,
  input  logic [15:0] I_B,
  input  logic [4:0]  I_STATUS_FLAGS,
  output logic [15:0] O_MEM_ADDRESS,
  output logic        O_MEM_WRITE_ENABLE,
  output logic [15:0] O_MEM_WRITE_DATA,
  output logic [15:0] O_REG_WRITE_ENABLE,
  output logic [3:0]  O_REG_A_SELECT,
  output logic [3:0]  O_REG_B_SELECT,
  output logic [15:0] O_IMMEDIATE,
  output logic        O_IMMEDIATE_SELECT,
  output logic [3:0]  O_OPCODE,
  output logic [15:0] O_REGFILE_DATA,
  output logic        O_REGFILE_DATA_SELECT,
  output logic [15:0] O_PC,
  output logic [1:0]  O_STATE,
  output logic [4:0]  O_PSR
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_LOAD_WB = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  psr_q, psr_d;

  logic [3:0] op, rdest, ext, rsrc, code;
  logic [7:0] imm8;
  logic       is_alu, is_imm, is_cmp, is_mov, is_arith;
  logic       is_lui, is_load, is_stor, is_jcond, is_bcond, taken;

  // PSR bit order is {C,L,F,Z,N}.
  function automatic logic cond_met(input logic [3:0] c, input logic [4:0] f);
    case (c)
      4'b0000: cond_met = f[1];
      4'b0001: cond_met = !f[1];
      4'b0010: cond_met = f[4];
      4'b0011: cond_met = !f[4];
      4'b0110: cond_met = f[0];
      4'b0111: cond_met = !f[0];
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  // Register-form ALU ops carry the operation in ext; immediate forms reuse it as op.
  always_comb begin
    op       = ir_q[15:12];
    rdest    = ir_q[11:8];
    ext      = ir_q[7:4];
    rsrc     = ir_q[3:0];
    imm8     = ir_q[7:0];
    code     = (op == 4'b0000) ? ext : op;
    is_alu   = 1'b0;
    case (code)
      4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: is_alu = 1'b1;
      default: is_alu = 1'b0;
    endcase
    is_imm   = is_alu && (op != 4'b0000);
    is_cmp   = is_alu && (code == 4'b1011);
    is_mov   = is_alu && (code == 4'b1101);
    is_arith = is_alu && ((code == 4'b0101) || (code == 4'b1001) || (code == 4'b1011));
    is_lui   = (op == 4'b1111);
    is_load  = (op == 4'b0100) && (ext == 4'b0000);
    is_stor  = (op == 4'b0100) && (ext == 4'b0100);
    is_jcond = (op == 4'b0100) && (ext == 4'b1100);
    is_bcond = (op == 4'b1100);
    taken    = (is_jcond || is_bcond) && cond_met(rdest, psr_q);
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET_VALUE;
      ir_q    <= 16'h0000;
      psr_q   <= 5'b00000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    psr_d   = psr_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = I_MEM_DATA;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = is_load ? S_LOAD_WB : S_FETCH;
        if (!taken)        pc_d = pc_q + 16'd1;
        else if (is_jcond) pc_d = I_B;
        else               pc_d = pc_q + {{8{imm8[7]}}, imm8};
        if (is_arith) psr_d = I_STATUS_FLAGS;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    O_MEM_ADDRESS         = pc_q;
    O_MEM_WRITE_ENABLE    = 1'b0;
    O_MEM_WRITE_DATA      = 16'h0000;
    O_REG_WRITE_ENABLE    = 16'h0000;
    O_REG_A_SELECT        = is_mov ? rsrc : rdest;
    O_REG_B_SELECT        = rsrc;
    O_IMMEDIATE           = 16'h0000;
    O_IMMEDIATE_SELECT    = 1'b0;
    O_OPCODE              = 4'd0;
    O_REGFILE_DATA        = 16'h0000;
    O_REGFILE_DATA_SELECT = 1'b0;
    O_PC                  = pc_q;
    O_STATE               = state_q;
    O_PSR                 = psr_q;
    if (is_alu) begin
      case (code)
        4'b1001, 4'b1011: O_OPCODE = 4'd3;
        4'b0001:          O_OPCODE = 4'd5;
        4'b0010, 4'b1101: O_OPCODE = 4'd6;
        4'b0011:          O_OPCODE = 4'd7;
        default:          O_OPCODE = 4'd0;
      endcase
      O_IMMEDIATE        = is_arith ? {{8{imm8[7]}}, imm8} : {8'h00, imm8};
      O_IMMEDIATE_SELECT = is_imm && !is_mov;
    end
    if (is_imm && is_mov) begin
      O_REGFILE_DATA        = {8'h00, imm8};
      O_REGFILE_DATA_SELECT = 1'b1;
    end
    if (is_lui) begin
      O_REGFILE_DATA        = {imm8, 8'h00};
      O_REGFILE_DATA_SELECT = 1'b1;
    end
    if (state_q == S_EXECUTE) begin
      if ((is_alu && !is_cmp) || is_lui) O_REG_WRITE_ENABLE = 16'd1 << rdest;
      if (is_load || is_stor) O_MEM_ADDRESS = I_B;
      if (is_stor) begin
        O_MEM_WRITE_ENABLE = 1'b1;
        O_MEM_WRITE_DATA   = I_A;
      end
    end
    if ((state_q == S_LOAD_WB) && is_load) begin
      O_REGFILE_DATA        = I_MEM_DATA;
      O_REGFILE_DATA_SELECT = 1'b1;
      O_REG_WRITE_ENABLE    = 16'd1 << rdest;
    end
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multi-cycle CR16 control unit directly upstream of the datapath. It drives every datapath control input: register selects, one-hot write enable, ALU opcode, immediate, immediate select and regfile data select. It also owns the PC, the instruction register (IR), the processor status register (PSR) and the single-port memory interface. Memory is synchronous with 1-cycle read latency, and the same memory holds instructions and data.

Parameters:
PC_RESET_VALUE, 16'h0000, PC value loaded on reset.

Ports:
I_CLK  in  1  system clock; all state updates on the rising edge
I_NRESET  in  1  reset, asynchronous and active-low
I_MEM_DATA  in  16  memory read data, valid the cycle after address issue
I_A  in  16  datapath O_A (contents of reg A select)
I_B  in  16  datapath O_B (contents of reg B select)
I_STATUS_FLAGS  in  5  datapath flags {C,L,F,Z,N}, bit4..bit0
O_MEM_ADDRESS  out  16  memory word address
O_MEM_WRITE_ENABLE  out  1  memory write strobe
O_MEM_WRITE_DATA  out  16  store data
O_REG_WRITE_ENABLE  out  16  one-hot regfile write enable
O_REG_A_SELECT  out  4  datapath A select
O_REG_B_SELECT  out  4  datapath B select
O_IMMEDIATE  out  16  extended immediate
O_IMMEDIATE_SELECT  out  1  1 = immediate replaces B
O_OPCODE  out  4  ALU opcode (ADD=0, SUB=3, AND=5, OR=6, XOR=7)
O_REGFILE_DATA  out  16  alternate regfile write data
O_REGFILE_DATA_SELECT  out  1  1 = regfile writes O_REGFILE_DATA
O_PC  out  16  current PC (debug)

Behaviour:
- Reset (async, I_NRESET=0):
  - state=FETCH, PC=PC_RESET_VALUE, IR=0, PSR=0.
  - All write enables and strobes 0; all other outputs 0.
  - Reset asserted mid-instruction aborts it; no partial reg/mem write or PC update occurs.
- States:
  - FETCH: O_MEM_ADDRESS=PC; next DECODE.
  - DECODE: IR<=I_MEM_DATA at the clock edge; next EXECUTE.
  - EXECUTE: next LOAD_WB for LOAD, else FETCH.
  - LOAD_WB: next FETCH.
- Outputs are combinational from state and IR. Outside EXECUTE and LOAD_WB, write enables are 0.
- IR fields: op=[15:12], rdest=[11:8], ext=[7:4], rsrc=[3:0], imm8=[7:0]. A select=rdest, B select=rsrc.
- Register ops (op 0000), rdest <= rdest OP rsrc:
  - ext 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR.
  - ext 1011 CMP: SUB with no write.
  - ext 1101 MOV: OR with B select=A select=rsrc.
- Immediate ops use op as the ext code above: ADDI, SUBI, CMPI, ANDI, ORI, XORI, MOVI.
  - ADDI/SUBI/CMPI: sign-extend imm8.
  - ANDI/ORI/XORI: zero-extend imm8.
  - MOVI: O_REGFILE_DATA=zext(imm8), REGFILE_DATA_SELECT=1.
  - op 1111 LUI: O_REGFILE_DATA={imm8,8'h00}.
- Write: O_REG_WRITE_ENABLE=1<<rdest for exactly one EXECUTE cycle.
- PSR: latched from I_STATUS_FLAGS at the end of EXECUTE for ADD/SUB/CMP and their immediate forms only. Logic ops, moves and memory ops leave PSR unchanged.
- op 0100, ext 0000 LOAD rdest,(rsrc):
  - EXECUTE: O_MEM_ADDRESS=I_B.
  - LOAD_WB: REGFILE_DATA=I_MEM_DATA, select=1, write rdest.
- op 0100, ext 0100 STOR rdest,(rsrc): EXECUTE drives O_MEM_ADDRESS=I_B, WRITE_DATA=I_A, WRITE_ENABLE=1.
- op 1100 Bcond: cond=[11:8]. If taken, PC <= PC + sext(imm8), where PC is the branch's own address.
- op 0100, ext 1100 Jcond: if taken, PC <= I_B.
- Condition codes:
  - 0000 EQ: Z=1. 0001 NE: Z=0.
  - 0010 CS: C=1. 0011 CC: C=0.
  - 0110 GT: N=1. 0111 LE: N=0.
  - 1110 UC: always taken.
  - All other codes: never taken.
- PC update: at the end of EXECUTE, PC <= taken target else PC+1, mod 2^16 (FFFF wraps to 0000). Branch target arithmetic also wraps.
- Unrecognised encodings: NOP (no writes, PC+1).
- Latency: 3 cycles per instruction, 4 for LOAD.

Test Plan:
- Reset then MOVI r1,#5; ADDI r1,#-1 -> write enable 16'h0002 in each EXECUTE; r1 ends at 4; PC=2 after 6 cycles.
- CMP r2,r3 with equal values, then BEQ disp=-2 at PC=8 -> PC becomes 6. Repeat with unequal values -> PC becomes 9.
- STOR r4,(r5) with r4=16'hBEEF, r5=16'h0100, then LOAD r6,(r5) -> memory write strobe for one cycle at address 0x0100; r6=16'hBEEF after the 4-cycle load.
- PC at 16'hFFFF with NOP -> next fetch address 16'h0000. BUC disp=+1 at 16'hFFFF -> 16'h0000.
- Assert I_NRESET during EXECUTE of ADD -> no write enable seen; PC=PC_RESET_VALUE; state=FETCH.
- LUI r7,#8'hAB then JUC r7 -> r7=16'hAB00; next fetch address 16'hAB00; PSR unchanged.
